cell_stream_processor: RTL and testbench

- Parametrised, pipelined successor to the combinational single-cell processor.
- Accepts one cell pair plus opcode per valid/ready transfer and produces one registered result pixel on a valid/ready output.
- Generalised in channel width, channel count and cell dimension.
- Adds saturating arithmetic, MAX/MIN, and a multi-cycle AVG (box-mean) mode.
- Sits between the cell fetch/window logic and the result writeback path.

---
 rtl/cell_stream_processor.sv | 180 ++++++++++++++++++
 tb/tb_cell_stream_processor.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/cell_stream_processor.sv
// cell_stream_processor: pipelined per-channel cell operations with a
// valid/ready input and a registered valid/ready result pixel.
module cell_stream_processor #(
    parameter int unsigned CH_W     = 8,
    parameter int unsigned NUM_CH   = 3,
    parameter int unsigned CELL_DIM = 3
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic                                      in_valid,
    output logic                                      in_ready,
    input  logic [CELL_DIM*CELL_DIM*NUM_CH*CH_W-1:0]  cell_a,
    input  logic [CELL_DIM*CELL_DIM*NUM_CH*CH_W-1:0]  cell_b,
    input  logic [NUM_CH*CH_W-1:0]                    user_in,
    input  logic [2:0]                                opcode,
    output logic                                      out_valid,
    input  logic                                      out_ready,
    output logic [NUM_CH*CH_W-1:0]                    pixel_out,
    output logic                                      busy
);

    localparam int unsigned N     = CELL_DIM * CELL_DIM;
    localparam int unsigned CTR   = N / 2;
    localparam int unsigned ACC_W = CH_W + $clog2(N);
    localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ACCUM = 2'd1;
    localparam logic [1:0] ST_OUT   = 2'd2;

    localparam logic [2:0] OP_PASS = 3'd0;
    localparam logic [2:0] OP_ADD  = 3'd1;
    localparam logic [2:0] OP_ADDI = 3'd2;
    localparam logic [2:0] OP_SUB  = 3'd3;
    localparam logic [2:0] OP_SUBI = 3'd4;
    localparam logic [2:0] OP_MAX  = 3'd5;
    localparam logic [2:0] OP_MIN  = 3'd6;
    localparam logic [2:0] OP_AVG  = 3'd7;

    typedef logic [N-1:0][NUM_CH-1:0][CH_W-1:0] cell_t;
    typedef logic [NUM_CH-1:0][CH_W-1:0]        pix_t;

    logic [1:0]                   state;
    logic [1:0]                   state_next;
    logic                         accept;
    logic                         last;
    cell_t                        a_pix;
    cell_t                        b_pix;
    pix_t                         u_pix;
    cell_t                        cap;
    logic [NUM_CH-1:0][ACC_W-1:0] acc;
    logic [NUM_CH-1:0][ACC_W-1:0] acc_next;
    logic [IDX_W-1:0]             idx;
    pix_t                         point_res;
    pix_t                         avg_res;
    logic                         unused_cell_b;

    assign a_pix         = cell_a;
    assign b_pix         = cell_b;
    assign u_pix         = user_in;
    assign unused_cell_b = ^cell_b;
    assign accept        = in_valid && in_ready;
    assign last          = (idx == IDX_W'(N - 1));

    // Saturating single-channel pointwise operation on the centre pixels.
    function automatic logic [CH_W-1:0] op_chan(
        input logic [2:0]      op,
        input logic [CH_W-1:0] a,
        input logic [CH_W-1:0] b,
        input logic [CH_W-1:0] u
    );
        logic [CH_W:0]   sum_ab;
        logic [CH_W:0]   sum_au;
        logic [CH_W:0]   dif_ab;
        logic [CH_W:0]   dif_au;
        logic [CH_W-1:0] r;
        sum_ab = {1'b0, a} + {1'b0, b};
        sum_au = {1'b0, a} + {1'b0, u};
        dif_ab = {1'b0, a} - {1'b0, b};
        dif_au = {1'b0, a} - {1'b0, u};
        case (op)
            OP_ADD:  r = sum_ab[CH_W] ? '1 : sum_ab[CH_W-1:0];
            OP_ADDI: r = sum_au[CH_W] ? '1 : sum_au[CH_W-1:0];
            OP_SUB:  r = dif_ab[CH_W] ? '0 : dif_ab[CH_W-1:0];
            OP_SUBI: r = dif_au[CH_W] ? '0 : dif_au[CH_W-1:0];
            OP_MAX:  r = (a > b) ? a : b;
            OP_MIN:  r = (a < b) ? a : b;
            default: r = a;
        endcase
        return r;
    endfunction

    // Pointwise result from the live inputs, used on the accepting edge.
    always_comb begin
        point_res = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            point_res[c] = op_chan(opcode, a_pix[CTR][c], b_pix[CTR][c], u_pix[c]);
        end
    end

    // Running sum including the current pixel, and its round-half-up mean.
    always_comb begin
        acc_next = '0;
        avg_res  = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            acc_next[c] = acc[c] + ACC_W'(cap[idx][c]);
            avg_res[c]  = CH_W'((acc_next[c] + ACC_W'(CTR)) / ACC_W'(N));
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and input-ready decode.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        case (state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_next = (opcode == OP_AVG) ? ST_ACCUM : ST_OUT;
                end
            end
            ST_ACCUM: begin
                if (last) begin
                    state_next = ST_OUT;
                end
            end
            ST_OUT: begin
                in_ready = out_ready;
                if (out_ready) begin
                    if (in_valid) begin
                        state_next = (opcode == OP_AVG) ? ST_ACCUM : ST_OUT;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Datapath: result pixel, AVG capture/accumulation, status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pixel_out <= '1;
            cap       <= '0;
            acc       <= '0;
            idx       <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            out_valid <= (state_next == ST_OUT);
            busy      <= (state_next == ST_ACCUM);
            if (accept) begin
                if (opcode == OP_AVG) begin
                    cap <= a_pix;
                    acc <= '0;
                    idx <= '0;
                end else begin
                    pixel_out <= point_res;
                end
            end else if (state == ST_ACCUM) begin
                acc <= acc_next;
                idx <= idx + IDX_W'(1);
                if (last) begin
                    pixel_out <= avg_res;
                end
            end
        end
    end

endmodule

// File: tb/tb_cell_stream_processor.sv
// Scoreboard bench for cell_stream_processor: the stimulus pushes the
// expected pixel at each accepted transfer, a monitor pops on each handshake.
module tb_cell_stream_processor;

    localparam int unsigned CH_W     = 8;
    localparam int unsigned NUM_CH   = 3;
    localparam int unsigned CELL_DIM = 3;
    localparam int unsigned N        = CELL_DIM * CELL_DIM;
    localparam int unsigned CTR      = N / 2;
    localparam int unsigned PIX_W    = NUM_CH * CH_W;
    localparam int unsigned CELL_W   = N * PIX_W;

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [CELL_W-1:0] cell_a;
    logic [CELL_W-1:0] cell_b;
    logic [PIX_W-1:0]  user_in;
    logic [2:0]        opcode;
    logic              out_valid;
    logic              out_ready;
    logic [PIX_W-1:0]  pixel_out;
    logic              busy;

    int pass_cnt  = 0;
    int total_cnt = 0;
    logic [PIX_W-1:0] sb[$];
    logic [PIX_W-1:0] mon_exp;

    cell_stream_processor #(.CH_W(CH_W), .NUM_CH(NUM_CH), .CELL_DIM(CELL_DIM)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .cell_a(cell_a), .cell_b(cell_b), .user_in(user_in), .opcode(opcode),
        .out_valid(out_valid), .out_ready(out_ready), .pixel_out(pixel_out),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [PIX_W-1:0] px(input logic [7:0] c0, input logic [7:0] c1, input logic [7:0] c2);
        return {c2, c1, c0};
    endfunction

    // Cell with the given centre pixel and distinct filler elsewhere.
    function automatic logic [CELL_W-1:0] mk_cell(input logic [PIX_W-1:0] ctr);
        logic [CELL_W-1:0] c;
        c = '0;
        for (int p = 0; p < N; p++) begin
            c[p*PIX_W +: PIX_W] = (p == CTR) ? ctr : (24'hCC55AA ^ PIX_W'(p * 24'h010101));
        end
        return c;
    endfunction

    // Offer one transfer, wait (bounded) for acceptance, queue its result.
    task automatic send(input logic [2:0] op, input logic [PIX_W-1:0] a, input logic [PIX_W-1:0] b,
                        input logic [PIX_W-1:0] u, input logic [PIX_W-1:0] exp, input bit push);
        int waited;
        cell_a   = mk_cell(a);
        cell_b   = mk_cell(b);
        user_in  = u;
        opcode   = op;
        in_valid = 1'b1;
        waited   = 0;
        @(negedge clk);
        while (!in_ready && waited < 20) begin
            waited++;
            @(negedge clk);
        end
        if (!in_ready) check("accept_timeout", 64'(in_ready), 64'd1);
        @(posedge clk);
        if (push) sb.push_back(exp);
        #1;
        in_valid = 1'b0;
    endtask

    // Pointwise op followed by a latency-1 out_valid check.
    task automatic point(input string name, input logic [2:0] op, input logic [PIX_W-1:0] a,
                         input logic [PIX_W-1:0] b, input logic [PIX_W-1:0] u, input logic [PIX_W-1:0] exp);
        send(op, a, b, u, exp, 1'b1);
        @(negedge clk);
        check({name, "_latency"}, 64'(out_valid), 64'd1);
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare on every output handshake.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                total_cnt++;
                $display("FAIL unexpected_output: got %0h expected none", pixel_out);
            end else begin
                mon_exp = sb.pop_front();
                check("result", 64'(pixel_out), 64'(mon_exp));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    logic [CELL_W-1:0] avg_cell;
    logic [PIX_W-1:0]  stream_a[4];
    logic [PIX_W-1:0]  stream_b[4];
    logic [PIX_W-1:0]  stream_e[4];

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        cell_a    = '0;
        cell_b    = '0;
        user_in   = '0;
        opcode    = 3'd0;

        // Reset values.
        repeat (3) @(negedge clk);
        check("rst_pixel", 64'(pixel_out), 64'hFFFFFF);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("rel_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;

        // Pointwise operations.
        point("add_sat", 3'd1, px(8'hF0, 8'h10, 8'h80), px(8'h20, 8'h05, 8'h80), '0, px(8'hFF, 8'h15, 8'hFF));
        point("addi_sat", 3'd2, px(8'hF0, 8'h10, 8'h80), '0, px(8'h20, 8'h05, 8'h80), px(8'hFF, 8'h15, 8'hFF));
        point("subi_floor", 3'd4, px(8'h10, 8'h50, 8'h00), '0, px(8'h20, 8'h10, 8'h01), px(8'h00, 8'h40, 8'h00));
        point("sub_floor", 3'd3, px(8'h10, 8'h50, 8'h00), px(8'h20, 8'h10, 8'h01), '0, px(8'h00, 8'h40, 8'h00));
        point("max", 3'd5, px(8'd3, 8'd9, 8'd7), px(8'd5, 8'd2, 8'd7), '0, px(8'd5, 8'd9, 8'd7));
        point("min", 3'd6, px(8'd3, 8'd9, 8'd7), px(8'd5, 8'd2, 8'd7), '0, px(8'd3, 8'd2, 8'd7));

        // AVG: ch0 = pixel index, ch1 = 0xFF, ch2 = 5 in pixel 2 only.
        for (int p = 0; p < N; p++) begin
            avg_cell[p*PIX_W +: PIX_W] = px(8'(p), 8'hFF, (p == 2) ? 8'd5 : 8'd0);
        end
        cell_a   = avg_cell;
        opcode   = 3'd7;
        in_valid = 1'b1;
        @(negedge clk);
        check("avg_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        sb.push_back(px(8'd4, 8'hFF, 8'd1));
        #1;
        in_valid = 1'b0;
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            check("avg_accum_flags", 64'({busy, in_ready, out_valid}), 64'b100);
            if (k == 2) begin
                cell_a = '1;
                opcode = 3'd0;
            end
        end
        @(negedge clk);
        check("avg_done_flags", 64'({busy, out_valid}), 64'b01);
        @(posedge clk); #1;

        // Backpressure: result must hold while out_ready is low.
        out_ready = 1'b0;
        send(3'd1, px(8'h01, 8'h02, 8'h03), px(8'h04, 8'h05, 8'h06), '0, px(8'h05, 8'h07, 8'h09), 1'b1);
        stream_a[0] = px(8'h10, 8'h20, 8'h30); stream_b[0] = px(8'h01, 8'h02, 8'h03); stream_e[0] = px(8'h11, 8'h22, 8'h33);
        stream_a[1] = px(8'hFF, 8'h00, 8'h80); stream_b[1] = px(8'h01, 8'h00, 8'h7F); stream_e[1] = px(8'hFF, 8'h00, 8'hFF);
        stream_a[2] = px(8'h80, 8'h80, 8'h80); stream_b[2] = px(8'h80, 8'h7F, 8'h01); stream_e[2] = px(8'hFF, 8'hFF, 8'h81);
        stream_a[3] = px(8'h00, 8'h01, 8'hFE); stream_b[3] = px(8'h00, 8'hFE, 8'h01); stream_e[3] = px(8'h00, 8'hFF, 8'hFF);
        cell_a   = mk_cell(stream_a[0]);
        cell_b   = mk_cell(stream_b[0]);
        opcode   = 3'd1;
        in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("stall_pixel", 64'(pixel_out), 64'h090705);
            check("stall_flags", 64'({out_valid, in_ready}), 64'b10);
        end
        @(posedge clk); #1;

        // Four back-to-back ADDs.
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cell_a   = mk_cell(stream_a[i]);
            cell_b   = mk_cell(stream_b[i]);
            opcode   = 3'd1;
            in_valid = 1'b1;
            @(negedge clk);
            check("stream_flags", 64'({out_valid, in_ready}), 64'b11);
            @(posedge clk);
            sb.push_back(stream_e[i]);
            #1;
        end
        in_valid = 1'b0;
        @(negedge clk);
        check("stream_last_valid", 64'(out_valid), 64'd1);
        @(posedge clk); #1;

        // Reset while accumulating at idx=4.
        send(3'd7, px(8'h11, 8'h22, 8'h33), '0, '0, '0, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_pixel", 64'(pixel_out), 64'hFFFFFF);
        check("abort_flags", 64'({out_valid, busy}), 64'b00);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        point("pass", 3'd0, px(8'd1, 8'd2, 8'd3), '0, '0, px(8'd1, 8'd2, 8'd3));

        repeat (2) @(posedge clk);
        #1;
        check("queue_drained", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
